// File: rtl/dmem_bus_ctrl_if.sv
// Pipeline-to-data-memory bus bundle for dmem_bus_ctrl.
// master = the controller, slave = pipeline plus memory side.
interface dmem_bus_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output stall, rsp_valid, rsp_rdata, fault,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_be
  );

  modport slave (
    output req_valid, req_we, req_addr,
    output req_wdata, req_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  stall, rsp_valid, rsp_rdata, fault,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_be
  );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: IDLE/REQ/WAIT/DONE request sequencer.
// Define DMEM_TIMEOUT_EN to abort stuck bus transfers after TIMEOUT cycles.
module dmem_bus_ctrl #(
  parameter int TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst_n,
  dmem_bus_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("dmem_bus_ctrl: TIMEOUT must be 2..255");
  end

`ifdef DMEM_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       expired;

  assign expired = (cnt_q == CntLast);
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    fault_d = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (|bus.req_be) begin
            we_d    = bus.req_we;
            addr_d  = bus.req_addr[31:2];
            wdata_d = bus.req_wdata;
            be_d    = bus.req_be;
            state_d = REQ;
`ifdef DMEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            fault_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      REQ: begin
`ifdef DMEM_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (bus.mem_gnt) begin
          state_d = we_q ? DONE : WAIT;
`ifdef DMEM_TIMEOUT_EN
        end else if (expired) begin
          fault_d = 1'b1;
          rdata_d = '0;
          state_d = DONE;
`endif
        end
      end
      WAIT: begin
`ifdef DMEM_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (bus.mem_rvalid) begin
          rdata_d = bus.mem_rdata;
          state_d = DONE;
`ifdef DMEM_TIMEOUT_EN
        end else if (expired) begin
          fault_d = 1'b1;
          rdata_d = '0;
          state_d = DONE;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Bus strobes decode from the async-reset state, so reset kills them at once.
  assign bus.stall     = (state_q == IDLE && bus.req_valid)
                       || state_q == REQ || state_q == WAIT;
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.fault     = fault_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_we    = (state_q == REQ) && we_q;
  assign bus.mem_be    = (state_q == REQ) ? be_q : 4'b0000;
  assign bus.mem_addr  = {addr_q, 2'b00};
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Scoreboard bench for dmem_bus_ctrl: directed requests push expected
// responses, a negedge monitor pops and compares on every rsp_valid.
module tb_dmem_bus_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dmem_bus_ctrl_if bus();

  dmem_bus_ctrl #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] rd_model = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push(input logic f, input logic [31:0] rd);
    exp_t x;
    x.fault = f;
    x.rdata = rd;
    sb.push_back(x);
  endtask

  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_be    = be;
  endtask

  // Monitor: every completion must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_fault", {31'd0, bus.fault}, {31'd0, e.fault});
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
      end
    end
    if (bus.fault && !bus.rsp_valid)
      chk("fault_without_rsp", 32'd1, 32'd0);
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_be     = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    #2;
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_fault", {31'd0, bus.fault}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Store, granted on first REQ cycle
    @(negedge clk);
    issue(1'b1, 32'h1000_0006, 32'h00AB_0000, 4'b0100);
    bus.mem_gnt = 1'b1;
    push(1'b0, rd_model);
    #1 chk("st_c0_stall", {31'd0, bus.stall}, 32'd1);
    chk("st_c0_mem_req", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1 chk("st_c1_mem_req", {31'd0, bus.mem_req}, 32'd1);
    chk("st_c1_addr", bus.mem_addr, 32'h1000_0004);
    chk("st_c1_be", {28'd0, bus.mem_be}, 32'h4);
    chk("st_c1_we", {31'd0, bus.mem_we}, 32'd1);
    chk("st_c1_wdata", bus.mem_wdata, 32'h00AB_0000);
    chk("st_c1_stall", {31'd0, bus.stall}, 32'd1);
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    #1 chk("st_c2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("st_c2_stall", {31'd0, bus.stall}, 32'd0);
    chk("st_c2_mem_req", {31'd0, bus.mem_req}, 32'd0);

    // Load, grant cycle 1, rvalid cycle 3
    @(negedge clk);
    issue(1'b0, 32'h2000_0000, 32'd0, 4'b1111);
    rd_model = 32'hDEAD_BEEF;
    push(1'b0, rd_model);
    #1 chk("ld_c0_stall", {31'd0, bus.stall}, 32'd1);
    @(negedge clk);
    bus.mem_gnt = 1'b1;
    #1 chk("ld_c1_mem_req", {31'd0, bus.mem_req}, 32'd1);
    chk("ld_c1_we", {31'd0, bus.mem_we}, 32'd0);
    chk("ld_c1_stall", {31'd0, bus.stall}, 32'd1);
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    #1 chk("ld_c2_stall", {31'd0, bus.stall}, 32'd1);
    chk("ld_c2_mem_req", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    #1 chk("ld_c3_stall", {31'd0, bus.stall}, 32'd1);
    chk("ld_c3_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.req_valid  = 1'b0;
    #1 chk("ld_c4_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("ld_c4_stall", {31'd0, bus.stall}, 32'd0);

    // Illegal access: be == 0
    @(negedge clk);
    issue(1'b0, 32'h2000_0001, 32'd0, 4'b0000);
    push(1'b1, rd_model);
    #1 chk("il_c0_mem_req", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1 chk("il_c1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("il_c1_fault", {31'd0, bus.fault}, 32'd1);
    chk("il_c1_mem_req", {31'd0, bus.mem_req}, 32'd0);

    // Store with grant withheld 5 cycles; stray rvalid must be ignored
    @(negedge clk);
    issue(1'b1, 32'h3000_000B, 32'h5A00_0000, 4'b1000);
    push(1'b0, rd_model);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h1111_1111;
      #1 chk($sformatf("dg_c%0d_req", i), {31'd0, bus.mem_req}, 32'd1);
      chk($sformatf("dg_c%0d_addr", i), bus.mem_addr, 32'h3000_0008);
      chk($sformatf("dg_c%0d_wdata", i), bus.mem_wdata, 32'h5A00_0000);
      chk($sformatf("dg_c%0d_be", i), {28'd0, bus.mem_be}, 32'h8);
    end
    @(negedge clk);
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b0;
    #1 chk("dg_c6_mem_req", {31'd0, bus.mem_req}, 32'd1);
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    #1 chk("dg_c7_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    @(negedge clk);

    // Load never granted
    @(negedge clk);
    issue(1'b0, 32'h5000_0000, 32'd0, 4'b1111);
`ifdef DMEM_TIMEOUT_EN
    rd_model = 32'd0;
    push(1'b1, rd_model);
    repeat (17) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
    #1 chk("to_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    @(negedge clk);
    #1 chk("to_mem_req_after", {31'd0, bus.mem_req}, 32'd0);
`else
    begin
      int hi;
      hi = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1 if (bus.stall && bus.mem_req) hi++;
      end
      chk("ng_stall_hold", hi, 32'd40);
    end
    #2 rst_n = 1'b0;
    #1 chk("ng_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("ng_rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("ng_rst_rdata", bus.rsp_rdata, 32'd0);
    rd_model = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Reset while waiting for load data
    @(negedge clk);
    issue(1'b0, 32'h6000_0000, 32'd0, 4'b1111);
    @(negedge clk);
    bus.mem_gnt   = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    #1 chk("rw_wait_stall", {31'd0, bus.stall}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h7777_7777;
    #1 chk("rw_rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rw_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rw_rst_rdata", bus.rsp_rdata, 32'd0);
    rd_model = 32'd0;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("rw_no_pulse", {31'd0, bus.rsp_valid}, 32'd0);

    // Back-to-back store then load
    @(negedge clk);
    issue(1'b1, 32'h4000_0000, 32'h1234_5678, 4'b1111);
    bus.mem_gnt = 1'b1;
    push(1'b0, rd_model);
    @(negedge clk);
    #1 chk("bb_st_we", {31'd0, bus.mem_we}, 32'd1);
    @(negedge clk);
    issue(1'b0, 32'h4000_0004, 32'd0, 4'b1111);
    push(1'b0, 32'hCAFE_F00D);
    #1 chk("bb_st_rsp", {31'd0, bus.rsp_valid}, 32'd1);
    chk("bb_done_stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    #1 chk("bb_ld_c0_stall", {31'd0, bus.stall}, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1 chk("bb_ld_c1_req", {31'd0, bus.mem_req}, 32'd1);
    chk("bb_ld_c1_we", {31'd0, bus.mem_we}, 32'd0);
    chk("bb_ld_c1_addr", bus.mem_addr, 32'h4000_0004);
    @(negedge clk);
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    #1 chk("bb_ld_rsp", {31'd0, bus.rsp_valid}, 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_bus_ctrl.md
DMEM_BUS_CTRL -- requirements
Module: dmem_bus_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 16, bus-wait cycle limit (used only when DMEM_TIMEOUT_EN is defined), legal range 2..255.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  pipeline memory request (load or store) present.
REQ-005 req_we  in  1  1 = store, 0 = load.
REQ-006 req_addr  in  32  byte address from the execute stage.
REQ-007 req_wdata  in  32  store data, already lane-positioned.
REQ-008 req_be  in  4  byte enables from the load/store byte-enable logic; 4'b0000 means a misaligned or illegal access.
REQ-009 stall  out  1  freeze the pipeline.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_rdata  out  32  raw load word, fed to the load extraction path as r_d.
REQ-012 fault  out  1  one-cycle pulse, coincident with rsp_valid, on an illegal access or timeout.
REQ-013 mem_req  out  1  bus request.
REQ-014 mem_we  out  1  bus write.
REQ-015 mem_addr  out  32  word address; bits [1:0] always 2'b00.
REQ-016 mem_wdata  out  32  bus write data.
REQ-017 mem_be  out  4  bus byte strobes.
REQ-018 mem_gnt  in  1  bus accepts the request this cycle.
REQ-019 mem_rvalid  in  1  load data valid; arrives no earlier than the cycle after mem_gnt.
REQ-020 mem_rdata  in  32  load data.

Function
REQ-021 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE.
REQ-022 IDLE, req_valid=1, req_be!=0: latch we/addr/wdata/be; go to REQ.
REQ-023 IDLE, req_valid=1, req_be==0: no bus access; go to DONE with fault flagged.
REQ-024 REQ: mem_req=1 with the latched fields, held stable until mem_gnt.
- Store granted: go to DONE.
- Load granted: go to WAIT.
REQ-025 WAIT: on mem_rvalid, capture mem_rdata into rsp_rdata; go to DONE.
REQ-026 DONE: rsp_valid=1 for exactly one cycle, stall=0, req_valid ignored; go to IDLE.
REQ-027 stall SHALL be 1 in IDLE while req_valid=1, and in REQ and WAIT; 0 otherwise.
REQ-028 Minimum latency, counted from the cycle the request first appears in IDLE:
- Store: rsp_valid in cycle 2.
- Load: rsp_valid in cycle 3.
REQ-029 rsp_rdata SHALL hold its value until the next load capture; stores and faults leave it unchanged, except a timeout (REQ-035).
REQ-030 mem_req, mem_we and mem_be SHALL be 0 outside REQ.
REQ-031 mem_addr SHALL equal {latched_addr[31:2], 2'b00}.
REQ-032 mem_rvalid in any state other than WAIT SHALL be ignored.

Reset
REQ-033 While rst_n=0, regardless of clock:
- state SHALL be IDLE.
- All registered outputs and latched fields SHALL be 0, including rsp_rdata.
- mem_req SHALL drop immediately, including mid-transaction.
- No rsp_valid or fault pulse SHALL follow reset release.

Configuration
REQ-034 Macro DMEM_TIMEOUT_EN defined: an 8-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT.
REQ-035 With DMEM_TIMEOUT_EN, when the counter reaches TIMEOUT-1 without progress:
- Go to DONE with fault=1 and rsp_rdata=0.
- mem_req deasserts on that transition.
REQ-036 Macro undefined: no counter; REQ and WAIT wait indefinitely; fault arises only from req_be==0.

Verification
REQ-037 Store, addr=0x1000_0006, be=4'b0100, wdata=0x00AB_0000, mem_gnt on first REQ cycle -> mem_addr=0x1000_0004, mem_be=4'b0100, stall high 2 cycles, rsp_valid in cycle 2, fault=0.
REQ-038 Load, addr=0x2000_0000, be=4'b1111, gnt in cycle 1, rvalid in cycle 3 with rdata=0xDEAD_BEEF -> rsp_valid in cycle 4, rsp_rdata=0xDEAD_BEEF, stall high cycles 0-3.
REQ-039 req_valid=1, be=4'b0000 -> no mem_req ever asserted, fault=1 and rsp_valid=1 in cycle 1.
REQ-040 Grant delayed 5 cycles -> mem_req, mem_addr, mem_wdata and mem_be stable across all 5 cycles; completion follows the grant per REQ-024/REQ-026.
REQ-041 DMEM_TIMEOUT_EN, TIMEOUT=16, load never granted -> fault=1 in DONE, rsp_rdata=0, mem_req low afterwards; without the macro, stall remains 1 indefinitely.
REQ-042 rst_n pulled low in WAIT -> mem_req=0 and stall=0 immediately; after release, a back-to-back store then load both complete correctly.
